// File: rtl/wheel_state_store.sv
// wheel_state_store: shadow-buffered wheel node/velocity store sequencing launch, collect and commit (optional macro WHEEL_FRAME_COUNT_EN adds a committed-frame counter)
module wheel_state_store #(
  parameter int POSITION_SIZE = 17,
  parameter int VELOCITY_SIZE = 12,
  parameter int NUM_NODES = 4
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            init_in,
  input  logic signed [POSITION_SIZE-1:0] init_nodes [1:0][NUM_NODES],
  input  logic                            run_en,
  input  logic signed [POSITION_SIZE-1:0] node_in_x,
  input  logic signed [POSITION_SIZE-1:0] node_in_y,
  input  logic                            node_in_valid,
  input  logic signed [VELOCITY_SIZE-1:0] velocity_in_x,
  input  logic signed [VELOCITY_SIZE-1:0] velocity_in_y,
  input  logic                            velocity_in_valid,
  input  logic                            result_in,
  output logic signed [POSITION_SIZE-1:0] nodes_out [1:0][NUM_NODES],
  output logic signed [VELOCITY_SIZE-1:0] velocities_out [1:0][NUM_NODES],
  output logic                            begin_out,
  output logic                            busy_out,
  output logic                            frame_error_out,
  output logic [15:0]                     frame_count_out
);
  localparam int CW = $clog2(NUM_NODES + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_NODES);
  typedef enum logic [1:0] {IDLE, LAUNCH, COLLECT, COMMIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] node_cnt_q, node_cnt_d, vel_cnt_q, vel_cnt_d;
  logic signed [POSITION_SIZE-1:0] shadow_nodes_q [1:0][NUM_NODES];
  logic signed [POSITION_SIZE-1:0] shadow_nodes_d [1:0][NUM_NODES];
  logic signed [VELOCITY_SIZE-1:0] shadow_vels_q [1:0][NUM_NODES];
  logic signed [VELOCITY_SIZE-1:0] shadow_vels_d [1:0][NUM_NODES];
  logic signed [POSITION_SIZE-1:0] nodes_q [1:0][NUM_NODES];
  logic signed [POSITION_SIZE-1:0] nodes_d [1:0][NUM_NODES];
  logic signed [VELOCITY_SIZE-1:0] vels_q [1:0][NUM_NODES];
  logic signed [VELOCITY_SIZE-1:0] vels_d [1:0][NUM_NODES];
  logic begin_q, begin_d, err_q, err_d;
  logic node_acc, vel_acc;
  // next state: init aborts anything; in COLLECT fill the shadow and judge completeness including this cycle's samples
  always_comb begin
    state_d = state_q;
    node_cnt_d = node_cnt_q;
    vel_cnt_d = vel_cnt_q;
    shadow_nodes_d = shadow_nodes_q;
    shadow_vels_d = shadow_vels_q;
    nodes_d = nodes_q;
    vels_d = vels_q;
    err_d = err_q;
    begin_d = 1'b0;
    node_acc = 1'b0;
    vel_acc = 1'b0;
    if (init_in) begin
      state_d = LAUNCH;
      nodes_d = init_nodes;
      vels_d = '{default: '0};
      node_cnt_d = '0;
      vel_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        LAUNCH: begin
          begin_d = 1'b1;
          node_cnt_d = '0;
          vel_cnt_d = '0;
          state_d = COLLECT;
        end
        COLLECT: begin
          node_acc = node_in_valid && node_cnt_q != FULL;
          vel_acc = velocity_in_valid && vel_cnt_q != FULL;
          err_d = err_q | (node_in_valid & ~node_acc) | (velocity_in_valid & ~vel_acc);
          node_cnt_d = node_cnt_q + CW'(node_acc);
          vel_cnt_d = vel_cnt_q + CW'(vel_acc);
          for (int i = 0; i < NUM_NODES; i++) begin
            if (node_acc && node_cnt_q == CW'(i)) begin
              shadow_nodes_d[0][i] = node_in_x;
              shadow_nodes_d[1][i] = node_in_y;
            end
            if (vel_acc && vel_cnt_q == CW'(i)) begin
              shadow_vels_d[0][i] = velocity_in_x;
              shadow_vels_d[1][i] = velocity_in_y;
            end
          end
          if (result_in) begin
            state_d = (node_cnt_d == FULL && vel_cnt_d == FULL) ? COMMIT : LAUNCH;
            err_d = err_d | (node_cnt_d != FULL) | (vel_cnt_d != FULL);
          end
        end
        COMMIT: begin
          nodes_d = shadow_nodes_q;
          vels_d = shadow_vels_q;
          state_d = run_en ? LAUNCH : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state and data registers with synchronous reset taking priority over init
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      node_cnt_q <= '0;
      vel_cnt_q <= '0;
      shadow_nodes_q <= '{default: '0};
      shadow_vels_q <= '{default: '0};
      nodes_q <= '{default: '0};
      vels_q <= '{default: '0};
      err_q <= 1'b0;
      begin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      node_cnt_q <= node_cnt_d;
      vel_cnt_q <= vel_cnt_d;
      shadow_nodes_q <= shadow_nodes_d;
      shadow_vels_q <= shadow_vels_d;
      nodes_q <= nodes_d;
      vels_q <= vels_d;
      err_q <= err_d;
      begin_q <= begin_d;
    end
  end
  assign nodes_out = nodes_q;
  assign velocities_out = vels_q;
  assign begin_out = begin_q;
  assign busy_out = state_q != IDLE;
  assign frame_error_out = err_q;
`ifdef WHEEL_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;
  // count only commits that land; an init in COMMIT cancels the copy and the count
  always_comb frame_count_d = (state_q == COMMIT && !init_in) ? frame_count_q + 16'd1 : frame_count_q;
  // frame counter register, wraps naturally at 16 bits
  always_ff @(posedge clk_in) frame_count_q <= rst_in ? '0 : frame_count_d;
  assign frame_count_out = frame_count_q;
`else
  assign frame_count_out = '0;
`endif
endmodule

// File: doc/wheel_state_store.md
WHEEL_STATE_STORE -- requirements
Module: wheel_state_store

Interface
REQ-001 Parameters SHALL be: POSITION_SIZE, default 17, node coordinate width; VELOCITY_SIZE, default 12, velocity width; NUM_NODES, default 4, nodes per wheel.
REQ-002 clk_in  input  1  system clock; the block SHALL use one clock only.
REQ-003 rst_in  input  1  synchronous, active-high reset.
REQ-004 init_in  input  1  single-cycle pulse that loads init_nodes and starts a run.
REQ-005 init_nodes  input  signed [POSITION_SIZE-1:0] [1:0][NUM_NODES]  initial node positions, index [0]=x, [1]=y.
REQ-006 run_en  input  1  permits automatic relaunch after each commit.
REQ-007 node_in_x / node_in_y  input  signed POSITION_SIZE each  streamed updated node.
REQ-008 node_in_valid  input  1  qualifies node_in_x/y.
REQ-009 velocity_in_x / velocity_in_y  input  signed VELOCITY_SIZE each  streamed updated velocity.
REQ-010 velocity_in_valid  input  1  qualifies velocity_in_x/y.
REQ-011 result_in  input  1  single-cycle end-of-frame pulse from the wheel updater.
REQ-012 nodes_out  output  signed [POSITION_SIZE-1:0] [1:0][NUM_NODES]  committed node positions.
REQ-013 velocities_out  output  signed [VELOCITY_SIZE-1:0] [1:0][NUM_NODES]  committed velocities.
REQ-014 begin_out  output  1  single-cycle pulse that starts the wheel updater.
REQ-015 busy_out  output  1  high in every state except IDLE.
REQ-016 frame_error_out  output  1  sticky flag set on an incomplete frame or an overflow.
REQ-017 frame_count_out  output  16  count of committed frames.

Function
REQ-018 FSM states SHALL be IDLE, LAUNCH, COLLECT, and COMMIT.
REQ-019 IDLE: the FSM SHALL move to LAUNCH on init_in and otherwise hold.
REQ-020 LAUNCH: begin_out SHALL be registered high for exactly one cycle, the node and velocity counters SHALL clear, and the FSM SHALL then move to COLLECT.
REQ-021 COLLECT: on node_in_valid with node_count < NUM_NODES, the sample SHALL be written to shadow_nodes[node_count] and node_count SHALL increment; velocities SHALL follow the same rule independently.
REQ-022 In COLLECT, a valid sample arriving when its count equals NUM_NODES SHALL be dropped and SHALL set frame_error_out.
REQ-023 The completeness check SHALL include any sample accepted in the same cycle as result_in.
REQ-024 On result_in in COLLECT, if both counts (including a same-cycle sample) equal NUM_NODES, the FSM SHALL move to COMMIT.
REQ-025 On result_in in COLLECT with an incomplete frame, frame_error_out SHALL set, the shadow data SHALL be discarded, nodes_out and velocities_out SHALL stay unchanged, and the FSM SHALL move to LAUNCH (retry).
REQ-026 COMMIT: shadow data SHALL copy to nodes_out and velocities_out at the next edge; the FSM SHALL then move to LAUNCH if run_en is high, else to IDLE.
REQ-027 Latency SHALL be: result_in sampled at edge E0, outputs updated at E1, begin_out high from E2 to E3.
REQ-028 init_in SHALL take priority over all other inputs in every state, including reset-free abort of COLLECT or COMMIT: init_nodes load into nodes_out, velocities_out clear, counters clear, and the FSM moves to LAUNCH.
REQ-029 node_in_valid, velocity_in_valid, and result_in SHALL be ignored outside COLLECT.
REQ-030 Data SHALL be stored without any width conversion or saturation.

Reset
REQ-031 On rst_in, the block SHALL enter IDLE with nodes_out, velocities_out, shadow data, counters, begin_out, frame_error_out, and frame_count_out all at 0.
REQ-032 rst_in SHALL take priority over init_in; asserting rst_in mid-COLLECT SHALL discard the frame and emit no begin_out.
REQ-033 frame_error_out SHALL clear only on rst_in.

Configuration
REQ-034 With WHEEL_FRAME_COUNT_EN defined, frame_count_out SHALL increment by 1 on each COMMIT and wrap from 16'hFFFF to 0; it SHALL not increment on retries.
REQ-035 Without WHEEL_FRAME_COUNT_EN, frame_count_out SHALL be tied to 0 and no counter SHALL be synthesised.

Verification
REQ-036 Reset, then init_in with init_nodes x={3,-2,2,3}, y={-2,2,2,-2} -> nodes_out equals init_nodes; begin_out is high exactly one cycle, two cycles after init_in.
REQ-037 In COLLECT, stream 4 nodes {(4,-3),(-1,1),(2,1),(4,-3)} and 4 zero velocities, then result_in with run_en=1 -> nodes_out is updated at E1, begin_out at E2, and frame_count_out=1 (macro on).
REQ-038 Stream 3 nodes and 4 velocities, then result_in -> frame_error_out=1, nodes_out unchanged, begin_out re-fires, and frame_count_out is unchanged.
REQ-039 Stream 5 node samples in one frame -> the 5th is dropped, frame_error_out=1, and shadow entries 0-3 hold the first four samples.
REQ-040 Send the 4th velocity in the same cycle as result_in -> the frame commits with no error; with run_en=0 the FSM goes to IDLE and busy_out=0.
REQ-041 Assert init_in mid-COLLECT after 2 nodes -> init_nodes are loaded, counters clear, and begin_out re-fires.
